// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
package serial_sub_pkg;

  typedef logic [1:0] sub_state_t;

  localparam sub_state_t S_IDLE = 2'd0;
  localparam sub_state_t S_RUN  = 2'd1;
  localparam sub_state_t S_DONE = 2'd2;

endpackage

// File: rtl/full_subtract.sv
// One-bit full subtractor cell: diff = a - b - c, borrow out when a < b + c.
module full_subtract (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic borrow
);

  always_comb begin
    diff   = a ^ b ^ c;
    borrow = (~a & b) | (~a & c) | (b & c);
  end

endmodule

// File: rtl/serial_subtract.sv
// Bit-serial unsigned subtractor a - b - bin, LSB first through one full_subtract
// cell, with valid/ready handshakes on operand input and result output.
module serial_subtract
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic             brw_r;
  logic [CW-1:0]    cnt;

  logic             cell_d;
  logic             cell_bo;
  logic [WIDTH-1:0] diff_next;

  full_subtract u_cell (
    .a      (a_sr[0]),
    .b      (b_sr[0]),
    .c      (brw_r),
    .diff   (cell_d),
    .borrow (cell_bo)
  );

  always_comb begin
    diff_next = {cell_d, diff_sr[WIDTH-1:1]};
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      brw_r      <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr    <= a_in;
            b_sr    <= b_in;
            brw_r   <= bin;
            cnt     <= '0;
            diff_sr <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          diff_sr <= diff_next;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          brw_r   <= cell_bo;
          // cnt holds at LAST instead of overflowing when WIDTH is a power of two
          if (cnt == LAST) begin
            diff       <= diff_next;
            borrow_out <= cell_bo;
            state      <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtract.sv
// Self-checking bench for serial_subtract at WIDTH=8 and WIDTH=16.
module tb_serial_subtract;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv8, ir8, ov8, or8, bin8, bo8;
  logic [7:0]  a8, b8, d8;
  logic        iv16, ir16, ov16, or16, bin16, bo16;
  logic [15:0] a16, b16, d16;

  int checks = 0;
  int passed = 0;

  serial_subtract #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
    .bin(bin8), .out_valid(ov8), .out_ready(or8), .diff(d8), .borrow_out(bo8)
  );

  serial_subtract #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a_in(a16), .b_in(b16),
    .bin(bin16), .out_valid(ov16), .out_ready(or16), .diff(d16), .borrow_out(bo16)
  );

  // Reference: plain signed arithmetic, borrow is the sign of the true result.
  function automatic void ref_sub(input int w, input int a, input int b, input int c,
                                  output int d, output bit bo);
    int r;
    r  = a - b - c;
    bo = (r < 0);
    d  = r & ((1 << w) - 1);
  endfunction

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int lat);
    @(negedge clk);
    a8 = a; b8 = b; bin8 = c; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    if (!ov8) lat = -1;
  endtask

  task automatic finish8;
    @(negedge clk);
    or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({ir8, ov8, bo8, d8} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset8: got ir=%b ov=%b bo=%b d=%h want ir=1 ov=0 bo=0 d=00", ir8, ov8, bo8, d8);
    else passed++;
    checks++;
    if ({ir16, ov16, bo16, d16} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset16: got ir=%b ov=%b bo=%b d=%h want ir=1 ov=0 bo=0 d=0000", ir16, ov16, bo16, d16);
    else passed++;
  endtask

  task automatic test_basic;
    int lat;
    start8(8'h5A, 8'h23, 1'b0, lat);
    checks++;
    if (lat !== 8) $display("FAIL latency: got %0d want 8", lat); else passed++;
    checks++;
    if ({bo8, d8} !== {1'b0, 8'h37})
      $display("FAIL basic_5A_23: got bo=%b d=%h want bo=0 d=37", bo8, d8);
    else passed++;
    finish8();
    checks++;
    if ({ir8, ov8} !== 2'b10)
      $display("FAIL transfer_to_idle: got ir=%b ov=%b want ir=1 ov=0", ir8, ov8);
    else passed++;
  endtask

  task automatic test_underflow;
    int lat;
    start8(8'h00, 8'h01, 1'b0, lat);
    checks++;
    if ({bo8, d8} !== {1'b1, 8'hFF} || lat !== 8)
      $display("FAIL underflow: got bo=%b d=%h lat=%0d want bo=1 d=ff lat=8", bo8, d8, lat);
    else passed++;
    finish8();
  endtask

  task automatic test_borrow_in;
    int lat;
    start8(8'h80, 8'h7F, 1'b1, lat);
    checks++;
    if ({bo8, d8} !== {1'b0, 8'h00})
      $display("FAIL bin_80_7F: got bo=%b d=%h want bo=0 d=00", bo8, d8);
    else passed++;
    finish8();
    start8(8'hFF, 8'hFF, 1'b1, lat);
    checks++;
    if ({bo8, d8} !== {1'b1, 8'hFF})
      $display("FAIL bin_FF_FF: got bo=%b d=%h want bo=1 d=ff", bo8, d8);
    else passed++;
    finish8();
  endtask

  task automatic test_back_pressure;
    int lat;
    start8(8'h12, 8'h34, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      iv8 = ~iv8; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({ov8, ir8, bo8, d8} !== {1'b1, 1'b0, 1'b1, 8'hDE})
        $display("FAIL hold_%0d: got ov=%b ir=%b bo=%b d=%h want ov=1 ir=0 bo=1 d=de", i, ov8, ir8, bo8, d8);
      else passed++;
    end
    @(negedge clk);
    iv8 = 1'b0; or8 = 1'b1;
    @(posedge clk);
    #1 or8 = 1'b0;
    checks++;
    if ({ov8, ir8, bo8, d8} !== {1'b0, 1'b1, 1'b1, 8'hDE})
      $display("FAIL release: got ov=%b ir=%b bo=%b d=%h want ov=0 ir=1 bo=1 d=de", ov8, ir8, bo8, d8);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if ({ov8, ir8} !== 2'b01)
      $display("FAIL no_capture: got ov=%b ir=%b want ov=0 ir=1", ov8, ir8);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    int  lat;
    bit  rose = 1'b0;
    @(negedge clk);
    a8 = 8'h5A; b8 = 8'h23; bin8 = 1'b0; iv8 = 1'b1;
    @(posedge clk);
    #1 iv8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({ov8, ir8, bo8, d8} !== {1'b0, 1'b1, 1'b0, 8'h00})
      $display("FAIL mid_reset: got ov=%b ir=%b bo=%b d=%h want ov=0 ir=1 bo=0 d=00", ov8, ir8, bo8, d8);
    else passed++;
    repeat (12) begin
      @(posedge clk);
      #1 if (ov8) rose = 1'b1;
    end
    checks++;
    if (rose !== 1'b0) $display("FAIL mid_reset_no_valid: got out_valid pulse=%b want 0", rose);
    else passed++;
    start8(8'h10, 8'h01, 1'b0, lat);
    checks++;
    if ({bo8, d8} !== {1'b0, 8'h0F} || lat !== 8)
      $display("FAIL after_reset_op: got bo=%b d=%h lat=%0d want bo=0 d=0f lat=8", bo8, d8, lat);
    else passed++;
    finish8();
  endtask

  task automatic test_back_to_back8;
    logic [8:0] q[$];
    int got = 0;
    bit tmo = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          int a, b, c, d;
          bit bo, acc;
          a = int'($urandom_range(0, 255));
          b = int'($urandom_range(0, 255));
          c = int'($urandom_range(0, 1));
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          a8 = 8'(a); b8 = 8'(b); bin8 = 1'(c); iv8 = 1'b1;
          acc = 1'b0;
          for (int w = 0; w < 64 && !acc; w++) begin
            if (w > 0) @(negedge clk);
            acc = ir8;
            @(posedge clk);
          end
          #1 iv8 = 1'b0;
          if (acc) begin
            ref_sub(8, a, b, c, d, bo);
            q.push_back({bo, 8'(d)});
          end else tmo = 1'b1;
        end
      end
      begin
        for (int cyc = 0; cyc < 20000 && got < 200; cyc++) begin
          @(negedge clk);
          or8 = ($urandom_range(0, 3) != 0);
          if (ov8 && or8) begin
            checks++;
            if (q.size() == 0)
              $display("FAIL stream8_extra: got bo=%b d=%h with no operation pending", bo8, d8);
            else begin
              logic [8:0] e;
              e = q.pop_front();
              if ({bo8, d8} !== e)
                $display("FAIL stream8_result %0d: got bo=%b d=%h want bo=%b d=%h", got, bo8, d8, e[8], e[7:0]);
              else passed++;
            end
            got++;
          end
        end
        @(posedge clk);
        #1 or8 = 1'b0;
      end
    join
    checks++;
    if (got !== 200 || q.size() !== 0 || tmo)
      $display("FAIL stream8_count: got %0d results pending=%0d timeout=%b want 200 pending=0 timeout=0", got, q.size(), tmo);
    else passed++;
  endtask

  task automatic test_back_to_back16;
    logic [16:0] q[$];
    int got = 0;
    bit tmo = 1'b0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          int a, b, c, d;
          bit bo, acc;
          a = int'($urandom_range(0, 65535));
          b = int'($urandom_range(0, 65535));
          c = int'($urandom_range(0, 1));
          repeat ($urandom_range(0, 3)) @(negedge clk);
          @(negedge clk);
          a16 = 16'(a); b16 = 16'(b); bin16 = 1'(c); iv16 = 1'b1;
          acc = 1'b0;
          for (int w = 0; w < 64 && !acc; w++) begin
            if (w > 0) @(negedge clk);
            acc = ir16;
            @(posedge clk);
          end
          #1 iv16 = 1'b0;
          if (acc) begin
            ref_sub(16, a, b, c, d, bo);
            q.push_back({bo, 16'(d)});
          end else tmo = 1'b1;
        end
      end
      begin
        for (int cyc = 0; cyc < 30000 && got < 200; cyc++) begin
          @(negedge clk);
          or16 = ($urandom_range(0, 3) != 0);
          if (ov16 && or16) begin
            checks++;
            if (q.size() == 0)
              $display("FAIL stream16_extra: got bo=%b d=%h with no operation pending", bo16, d16);
            else begin
              logic [16:0] e;
              e = q.pop_front();
              if ({bo16, d16} !== e)
                $display("FAIL stream16_result %0d: got bo=%b d=%h want bo=%b d=%h", got, bo16, d16, e[16], e[15:0]);
              else passed++;
            end
            got++;
          end
        end
        @(posedge clk);
        #1 or16 = 1'b0;
      end
    join
    checks++;
    if (got !== 200 || q.size() !== 0 || tmo)
      $display("FAIL stream16_count: got %0d results pending=%0d timeout=%b want 200 pending=0 timeout=0", got, q.size(), tmo);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_borrow_in();
    test_back_pressure();
    test_reset_mid_run();
    test_back_to_back8();
    test_back_to_back16();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule

// File: doc/serial_subtract.md
# serial_subtract

Bit-serial N-bit unsigned subtractor computing a − b − bin one bit per clock, LSB first, through a single 1-bit `full_subtract` cell. It sits directly upstream of that cell: it shifts operand bits and the registered borrow into the cell and collects the difference and borrow it produces. Operands enter and results leave over valid/ready handshakes, so the block drops into a streaming datapath. This trades area for latency against a ripple array of cells.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands `a_in`, `b_in`, `bin` are valid.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a_in`  in  WIDTH  minuend, unsigned.
- `b_in`  in  WIDTH  subtrahend, unsigned.
- `bin`  in  1  borrow-in to bit 0.
- `out_valid`  out  1  `diff` and `borrow_out` hold a completed result.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  (a − b − bin) mod 2^WIDTH.
- `borrow_out`  out  1  borrow from the MSB; 1 iff a < b + bin, unsigned.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - `in_ready` = 1 and `out_valid` = 0.
  - When `in_valid & in_ready`:
    - Load `a_sr` ← `a_in`, `b_sr` ← `b_in`, `brw_r` ← `bin`.
    - Clear `cnt` ← 0 and `diff_sr` ← 0.
    - Go to RUN.
- **RUN**
  - Each cycle the cell sees inputs (`a_sr[0]`, `b_sr[0]`, `brw_r`) and outputs (d, bo).
  - `diff_sr` ← {d, `diff_sr[WIDTH-1:1]`}.
  - `a_sr` and `b_sr` shift right by 1.
  - `brw_r` ← bo and `cnt` ← `cnt` + 1.
  - When `cnt` == WIDTH−1, go to DONE.
  - On that same edge, load `diff` ← {d, `diff_sr[WIDTH-1:1]`} and `borrow_out` ← bo.
  - `in_ready` = 0 and `out_valid` = 0 throughout RUN.
- **DONE**
  - `out_valid` = 1 and `in_ready` = 0.
  - `diff` and `borrow_out` are stable.
  - On `out_ready`, go to IDLE.
- `diff` and `borrow_out` change only on the RUN→DONE edge. They hold their last value in IDLE and RUN.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- `cnt` width is $clog2(WIDTH). `cnt` never wraps because the FSM leaves RUN at WIDTH−1.
- Reset in any state, including mid-RUN:
  - Next state is IDLE and the operation is discarded with no `out_valid` pulse.
  - `diff` = 0, `borrow_out` = 0, `out_valid` = 0.
  - `in_ready` = 1 from the cycle after the reset edge.
  - Shift registers, `cnt` and `brw_r` are cleared.

## Timing
- Accept edge = E0 (`in_valid & in_ready` sampled high).
- Bit i is computed on edge E(i+1), for i = 0 … WIDTH−1.
- `out_valid` rises after edge E(WIDTH): latency is WIDTH cycles from accept to result.
- With `out_ready` held high, the result transfers on E(WIDTH+1) and `in_ready` is high after it. The next accept can occur at E(WIDTH+2).
- Throughput with no back-pressure is one operation per WIDTH+2 cycles.
- Operations never overlap.
- The `full_subtract` path is purely combinational between registers. There is no combinational path from any input port to any output port.

## Structure
- Shared package `serial_sub_pkg` holds the state encoding constants:
  - `S_IDLE` = 2'd0
  - `S_RUN` = 2'd1
  - `S_DONE` = 2'd2
- One sub-module instance: the existing `full_subtract` cell, ports (a, b, c, diff, borrow).
- Everything else lives in `serial_subtract`: shift registers, counter, borrow flop, FSM and output registers.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, bin=0 -> `diff`=0x37, `borrow_out`=0; `out_valid` rises exactly 8 cycles after the accept edge.
- a=0x00, b=0x01, bin=0 -> `diff`=0xFF, `borrow_out`=1 (underflow wrap).
- a=0x80, b=0x7F, bin=1 -> `diff`=0x00, `borrow_out`=0; then a=0xFF, b=0xFF, bin=1 -> `diff`=0xFF, `borrow_out`=1.
- Back-pressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `in_valid` with new operands.
  - Required: `diff`/`borrow_out` stable, `in_ready`=0, new operands not captured.
  - On release: one transfer, then IDLE.
- Assert `rst` for 1 cycle after bit 3 of a RUN (a=0x5A, b=0x23).
  - Required: `out_valid` never rises; `in_ready`=1 the next cycle; outputs read 0.
  - A following op a=0x10, b=0x01, bin=0 -> `diff`=0x0F, `borrow_out`=0.
- Back-to-back stream of 200 random (a, b, bin) with random `in_valid`/`out_ready` gaps, WIDTH=8 and WIDTH=16 -> every result matches the reference model {borrow, diff} = a − b − bin; no result is dropped or duplicated.
